retire_gen: RTL and testbench
=============================

RETIRE_GEN -- requirements
Module: retire_gen

Interface
REQ-001 SHALL have parameter LAT_W, default 8: width of the per-transaction latency field.
REQ-002 SHALL have parameter DEPTH, default 8: maximum outstanding transactions, power of two, at least 2.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port issue  in  1  request pulse; one transaction per cycle high.
REQ-006 SHALL have port latency  in  LAT_W  requested issue-to-retire latency, sampled when issue is high.
REQ-007 SHALL have port clear  in  1  synchronous flush of all outstanding transactions.
REQ-008 SHALL have port issue_rdy  out  1  high when an issue would be accepted this cycle.
REQ-009 SHALL have port retire  out  1  registered completion pulse; one transaction per high cycle.
REQ-010 SHALL have port pending_cnt  out  $clog2(DEPTH+1)  outstanding transactions, registered.
REQ-011 SHALL have port drop_err  out  1  sticky flag: an issue was presented while issue_rdy was low.

Function
REQ-012 SHALL accept a transaction when issue=1, issue_rdy=1 and clear=0, storing max(latency,1) as its countdown in an in-order queue.
REQ-013 SHALL derive issue_rdy = (pending_cnt != DEPTH), from registered state only; a retire in the same cycle does not free a slot.
REQ-014 SHALL decrement every stored countdown by 1 each cycle and saturate it at 0.
REQ-015 SHALL drive retire high in cycle t+L for an isolated transaction accepted in cycle t with effective latency L.
REQ-016 SHALL retire strictly in issue order, at most one per cycle; an entry retires in cycle max(t+L, previous retire cycle+1).
REQ-017 SHALL update pending_cnt as +1 on accept, -1 on retire, unchanged when both occur in the same cycle, and 0 on clear.
REQ-018 SHALL set drop_err on issue=1 with issue_rdy=0 and clear=0, and hold it until clear or rst; the dropped issue SHALL not change any other state.
REQ-019 SHALL, on clear, discard all entries, drive retire low in the next cycle, zero pending_cnt and clear drop_err; clear SHALL win over a simultaneous issue or retire.
REQ-020 SHALL wrap queue pointers modulo DEPTH without loss or duplication.
REQ-021 SHALL keep the count of retire pulses after reset or clear no greater than the count of accepted issues.

Reset
REQ-022 SHALL, while rst is high, force retire=0, pending_cnt=0, drop_err=0, issue_rdy=1, with an empty queue.
REQ-023 SHALL, when rst asserts mid-operation, discard in-flight transactions with no retire for them after deassertion.

Configuration
REQ-024 SHALL add an input retire_stall (1 bit) when macro RETIRE_GEN_STALL_EN is defined.
REQ-025 SHALL, with RETIRE_GEN_STALL_EN defined and retire_stall=1 in cycle c, keep retire low in cycle c and hold the head entry; countdowns SHALL continue to run.
REQ-026 SHALL, without RETIRE_GEN_STALL_EN, omit the retire_stall port and behave as if retire_stall were 0.

Verification
REQ-027 SHALL cover: reset release, then issue with latency=5 in cycle 10 -> retire high only in cycle 15; pending_cnt 1 in cycles 11-15, then 0.
REQ-028 SHALL cover: issue with latency=0 in cycle 3 -> retire in cycle 4.
REQ-029 SHALL cover: issue latency=6 in cycle 0 and latency=1 in cycle 1 -> retires in cycles 6 and 7 (in order).
REQ-030 SHALL cover: 8 back-to-back issues with latency=20 and DEPTH=8 -> issue_rdy low; a 9th issue -> drop_err=1; then 8 retires in cycles 20-27, pending_cnt=0.
REQ-031 SHALL cover: clear in cycle 4 with 3 entries pending and issue=1 -> pending_cnt=0, no retire afterwards, drop_err=0, issue not accepted.
REQ-032 SHALL cover: with RETIRE_GEN_STALL_EN, latency=2 issue in cycle 0 and retire_stall high in cycles 2-4 -> retire in cycle 5.

Source files
------------

// File: rtl/retire_gen.sv
// retire_gen: in-order latency queue that emits one retire pulse per accepted
// transaction once its requested latency has elapsed.
// Optional feature macro: RETIRE_GEN_STALL_EN adds the retire_stall input,
// which holds the head entry and suppresses retire while high.
module retire_gen #(
    parameter int unsigned LAT_W = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue,
    input  logic [LAT_W-1:0]             latency,
    input  logic                         clear,
`ifdef RETIRE_GEN_STALL_EN
    input  logic                         retire_stall,
`endif
    output logic                         issue_rdy,
    output logic                         retire,
    output logic [$clog2(DEPTH+1)-1:0]   pending_cnt,
    output logic                         drop_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Per-slot countdowns; value 0 means the entry is due.
    logic [LAT_W-1:0] cnt_q [DEPTH];
    logic [LAT_W-1:0] cnt_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] pend_d;
    logic             retire_q, retire_d;
    logic             rdy_d;
    logic             drop_d;
    logic             stall_c;
    logic             accept_c;
    logic             pop_c;
    logic [LAT_W-1:0] lat_m1_c;

`ifdef RETIRE_GEN_STALL_EN
    assign stall_c = retire_stall;
`else
    assign stall_c = 1'b0;
`endif

    // retire_q tracks "head is due"; a stall only masks the pulse this cycle.
    assign retire   = retire_q & ~stall_c;
    assign pop_c    = retire;
    assign accept_c = issue & issue_rdy & ~clear;
    // A new entry is stored one tick ahead, since it is first observed a cycle later.
    assign lat_m1_c = (latency == '0) ? '0 : latency - LAT_W'(1);

    // Next-state computation: countdowns, pointers, occupancy and flags.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i] = (cnt_q[i] == '0) ? '0 : cnt_q[i] - LAT_W'(1);
        end
        rd_d     = rd_q + PTR_W'(pop_c);
        wr_d     = wr_q + PTR_W'(accept_c);
        pend_d   = pending_cnt + CNT_W'(accept_c) - CNT_W'(pop_c);
        drop_d   = drop_err | (issue & ~issue_rdy);
        retire_d = 1'b0;
        rdy_d    = 1'b1;

        if (accept_c) begin
            cnt_d[wr_q] = lat_m1_c;
        end

        // Next head may be the entry being written this cycle (empty-queue bypass).
        retire_d = (pend_d != '0) && (cnt_d[rd_d] == '0);
        rdy_d    = (pend_d != CNT_W'(DEPTH));

        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_d[i] = '0;
            end
            rd_d     = '0;
            wr_d     = '0;
            pend_d   = '0;
            drop_d   = 1'b0;
            retire_d = 1'b0;
            rdy_d    = 1'b1;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
            rd_q        <= '0;
            wr_q        <= '0;
            pending_cnt <= '0;
            retire_q    <= 1'b0;
            issue_rdy   <= 1'b1;
            drop_err    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            pending_cnt <= pend_d;
            retire_q    <= retire_d;
            issue_rdy   <= rdy_d;
            drop_err    <= drop_d;
        end
    end

endmodule

// File: tb/tb_retire_gen.sv
// Directed self-checking bench for retire_gen (DEPTH=8, LAT_W=8).
module tb_retire_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue;
    logic [7:0] latency;
    logic       clear;
`ifdef RETIRE_GEN_STALL_EN
    logic       retire_stall;
`endif
    logic       issue_rdy;
    logic       retire;
    logic [3:0] pending_cnt;
    logic       drop_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    retire_gen #(.LAT_W(8), .DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .latency     (latency),
        .clear       (clear),
`ifdef RETIRE_GEN_STALL_EN
        .retire_stall(retire_stall),
`endif
        .issue_rdy   (issue_rdy),
        .retire      (retire),
        .pending_cnt (pending_cnt),
        .drop_err    (drop_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge: outputs of the new cycle are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        issue = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst     = 1'b1;
        issue   = 1'b0;
        latency = '0;
        clear   = 1'b0;
`ifdef RETIRE_GEN_STALL_EN
        retire_stall = 1'b0;
`endif
        step();
        step();
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_pending", 32'(pending_cnt), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk("rst_rdy", 32'(issue_rdy), 32'd1);
        rst = 1'b0;

        // Latency 5 issued in cycle 10 retires in cycle 15.
        for (int c = 0; c <= 17; c++) begin
            chk("l5_retire", 32'(retire), 32'(c == 15));
            chk("l5_pending", 32'(pending_cnt), 32'(c >= 11 && c <= 15));
            issue   = (c == 10);
            latency = 8'd5;
            step();
        end
        idle(2);

        // Latency 0 behaves as 1: issue in cycle 3, retire in cycle 4.
        for (int c = 0; c <= 6; c++) begin
            chk("l0_retire", 32'(retire), 32'(c == 4));
            chk("l0_pending", 32'(pending_cnt), 32'(c == 4));
            issue   = (c == 3);
            latency = 8'd0;
            step();
        end
        idle(2);

        // Back-to-back latency 1: accept and retire coincide in cycle 1.
        for (int c = 0; c <= 4; c++) begin
            chk("l1_retire", 32'(retire), 32'(c == 1 || c == 2));
            chk("l1_pending", 32'(pending_cnt), 32'(c == 1 || c == 2));
            issue   = (c <= 1);
            latency = 8'd1;
            step();
        end
        idle(2);

        // Ordering: latency 6 then latency 1 retire in cycles 6 and 7.
        for (int c = 0; c <= 9; c++) begin
            int ep;
            ep = (c == 1) ? 1 : (c >= 2 && c <= 6) ? 2 : (c == 7) ? 1 : 0;
            chk("ord_retire", 32'(retire), 32'(c == 6 || c == 7));
            chk("ord_pending", 32'(pending_cnt), 32'(ep));
            issue   = (c <= 1);
            latency = (c == 0) ? 8'd6 : 8'd1;
            step();
        end
        idle(3);

        // Fill to DEPTH with latency 20, drop a 9th issue, drain in cycles 20-27.
        for (int c = 0; c <= 29; c++) begin
            int ep;
            ep = (c <= 8) ? c : (c <= 20) ? 8 : (c <= 27) ? 28 - c : 0;
            chk("full_retire", 32'(retire), 32'(c >= 20 && c <= 27));
            chk("full_pending", 32'(pending_cnt), 32'(ep));
            chk("full_rdy", 32'(issue_rdy), 32'(ep != 8));
            chk("full_drop", 32'(drop_err), 32'(c >= 9));
            issue   = (c <= 8);
            latency = 8'd20;
            step();
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_drop", 32'(drop_err), 32'd0);
        idle(2);

        // Clear in cycle 4 with 3 pending and a simultaneous issue.
        for (int c = 0; c <= 20; c++) begin
            if (c == 4) chk("clr_pend_before", 32'(pending_cnt), 32'd3);
            if (c >= 5) begin
                chk("clr_retire", 32'(retire), 32'd0);
                chk("clr_pending", 32'(pending_cnt), 32'd0);
                chk("clr_drop0", 32'(drop_err), 32'd0);
                chk("clr_rdy", 32'(issue_rdy), 32'd1);
            end
            issue   = (c <= 2) || (c == 4);
            clear   = (c == 4);
            latency = 8'd10;
            step();
        end
        idle(2);

        // Reset mid-flight discards the pending entry.
        issue   = 1'b1;
        latency = 8'd3;
        step();
        issue = 1'b0;
        chk("mrst_pend_before", 32'(pending_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_pending", 32'(pending_cnt), 32'd0);
        chk("mrst_rdy", 32'(issue_rdy), 32'd1);
        step();
        rst = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            chk("mrst_retire", 32'(retire), 32'd0);
            chk("mrst_pend", 32'(pending_cnt), 32'd0);
            step();
        end

`ifdef RETIRE_GEN_STALL_EN
        // Latency 2 in cycle 0, stall in cycles 2-4: retire in cycle 5.
        for (int c = 0; c <= 8; c++) begin
            retire_stall = (c >= 2 && c <= 4);
            #1;
            chk("stall_retire", 32'(retire), 32'(c == 5));
            chk("stall_pending", 32'(pending_cnt), 32'(c >= 1 && c <= 5));
            issue   = (c == 0);
            latency = 8'd2;
            step();
        end
        retire_stall = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
